// File: rtl/text_vram_arbiter.sv
// text_vram_arbiter
//   Owns the single-port text VRAM and shares it between a row prefetcher
//   (priority) and an Avalon-MM CPU slave. The prefetcher copies the next
//   40-word text row into the inactive half of a double-buffered line store
//   during horizontal blanking; the active half feeds disp_data.
//
// Ports
//   pixel_clk, Reset          clock, synchronous active-high reset
//   DrawX, DrawY              raster position (800x525 total, 640x480 active)
//   disp_data                 line-buffer word for column DrawX[9:4]
//   avl_*                     CPU slave: addr/read/write/byteenable/writedata,
//                             readdata/waitrequest
//   vram_*                    VRAM port: addr/we/be/wdata out, rdata in (1-cycle)
//   pf_overrun                sticky: bank swapped before prefetch completed

// One line-buffer bank: synchronous write, combinational read.
module text_vram_linebuf #(
  parameter int DEPTH = 40,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          pixel_clk,
  input  logic          Reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge pixel_clk) begin
    if (Reset)   mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  // caller keeps raddr below DEPTH
  assign rdata = mem[raddr];
endmodule

module text_vram_arbiter (
  input  logic        pixel_clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [31:0] disp_data,
  input  logic [10:0] avl_addr,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic [3:0]  avl_byteenable,
  input  logic [31:0] avl_writedata,
  output logic [31:0] avl_readdata,
  output logic        avl_waitrequest,
  output logic [10:0] vram_addr,
  output logic        vram_we,
  output logic [3:0]  vram_be,
  output logic [31:0] vram_wdata,
  input  logic [31:0] vram_rdata,
  output logic        pf_overrun
);
  localparam int          NUM_BANKS  = 2;
  localparam int          ROW_WORDS  = 40;
  localparam int          STAGES     = 1;
  localparam logic [10:0] VRAM_WORDS = 11'd1200;

  typedef enum logic [1:0] {IDLE, CPU_RD, PREFETCH, PF_DRAIN} state_t;

  typedef struct packed {
    logic [10:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vram_cmd_t;

  state_t          state, state_nxt;
  vram_cmd_t       cmd;
  logic            pf_pending, active_bank, fill_bank, rd_oor;
  logic [4:0]      pf_row, next_row;
  logic [10:0]     pf_base;
  logic [5:0]      pf_cnt, cap_idx, rd_idx;
  logic [STAGES:0] vld_pipe;  // [0]: address on port, [1]: data on vram_rdata
  logic            trig_line, trigger, swap, pf_req, pf_start, pf_busy, cpu_in_range;

  logic [NUM_BANKS-1:0][31:0] lb_rdata;
  logic [NUM_BANKS-1:0]       lb_we;

  // Raster decode. Line 479 is the last visible line, so there is no row 30
  // to fetch; line 524 preloads row 0 for the next frame.
  assign trig_line = ((DrawY[3:0] == 4'hF) && (DrawY < 10'd479)) || (DrawY == 10'd524);
  assign trigger   = (DrawX == 10'd640) && trig_line;
  assign swap      = (DrawX == 10'd799) && trig_line;
  assign next_row  = (DrawY == 10'd524) ? 5'd0 : DrawY[8:4] + 5'd1;

  // A trigger seen in IDLE starts immediately; otherwise it waits as pf_pending.
  assign pf_req    = pf_pending | trigger;
  assign pf_start  = (state == IDLE) && pf_req;
  assign pf_busy   = pf_pending || (state == PREFETCH) || (state == PF_DRAIN);

  assign pf_base      = {1'b0, pf_row, 5'd0} + {3'd0, pf_row, 3'd0};  // row*40
  assign cpu_in_range = avl_addr < VRAM_WORDS;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pixel_clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pf_req)        state_nxt = PREFETCH;
        else if (avl_read) state_nxt = CPU_RD;
      end
      CPU_RD:   state_nxt = IDLE;
      PREFETCH: if (pf_cnt == 6'(ROW_WORDS - 1)) state_nxt = PF_DRAIN;
      PF_DRAIN: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // While Reset is high nothing is driven to the VRAM and nothing is
  // acknowledged, so an aborted access leaves no trace.
  always_comb begin
    cmd             = '0;
    avl_waitrequest = avl_read | avl_write;
    avl_readdata    = '0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (!pf_req) begin
            if (avl_read) begin
              cmd.addr = cpu_in_range ? avl_addr : 11'd0;
            end else if (avl_write) begin
              avl_waitrequest = 1'b0;
              if (cpu_in_range) begin
                cmd.addr  = avl_addr;
                cmd.we    = 1'b1;
                cmd.be    = avl_byteenable;
                cmd.wdata = avl_writedata;
              end
            end
          end
        end
        CPU_RD: begin
          avl_waitrequest = 1'b0;
          avl_readdata    = rd_oor ? 32'd0 : vram_rdata;
        end
        PREFETCH: cmd.addr = pf_base + {5'd0, pf_cnt};
        default: ;
      endcase
    end
  end

  assign vram_addr  = cmd.addr;
  assign vram_we    = cmd.we;
  assign vram_be    = cmd.be;
  assign vram_wdata = cmd.wdata;

  // ---------------- prefetch / bank control ----------------
  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      pf_pending  <= 1'b0;
      pf_row      <= '0;
      pf_cnt      <= '0;
      cap_idx     <= '0;
      fill_bank   <= 1'b0;
      active_bank <= 1'b0;
      pf_overrun  <= 1'b0;
      rd_oor      <= 1'b0;
      vld_pipe    <= '0;
    end else begin
      if (trigger) pf_row <= next_row;

      if (pf_start)     pf_pending <= 1'b0;
      else if (trigger) pf_pending <= 1'b1;

      // Fill target is fixed at start; a late swap makes the prefetch land
      // in the now-visible bank, which is what pf_overrun flags.
      if (pf_start) begin
        pf_cnt    <= '0;
        fill_bank <= ~active_bank;
      end else if (vld_pipe[0]) begin
        pf_cnt <= pf_cnt + 6'd1;
      end

      vld_pipe <= {vld_pipe[STAGES-1:0], state_nxt == PREFETCH};
      cap_idx  <= pf_cnt;

      if (swap) begin
        active_bank <= ~active_bank;
        if (pf_busy) pf_overrun <= 1'b1;
      end

      if ((state == IDLE) && !pf_req && avl_read) rd_oor <= !cpu_in_range;
    end
  end

  // ---------------- line buffers ----------------
  assign rd_idx = (DrawX[9:4] < 6'(ROW_WORDS)) ? DrawX[9:4] : 6'd0;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign lb_we[b] = vld_pipe[STAGES] && (fill_bank == 1'(b));
    text_vram_linebuf #(.DEPTH(ROW_WORDS), .W(32)) u_lb (
      .pixel_clk (pixel_clk),
      .Reset     (Reset),
      .we        (lb_we[b]),
      .waddr     (cap_idx),
      .wdata     (vram_rdata),
      .raddr     (rd_idx),
      .rdata     (lb_rdata[b])
    );
  end

  assign disp_data = lb_rdata[active_bank];
endmodule

// File: tb/tb_text_vram_arbiter.sv
// Directed bench for text_vram_arbiter with a behavioural 1-cycle-latency VRAM.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_text_vram_arbiter;
  logic        pixel_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic [31:0] disp_data;
  logic [10:0] avl_addr;
  logic        avl_read, avl_write;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_writedata, avl_readdata;
  logic        avl_waitrequest;
  logic [10:0] vram_addr;
  logic        vram_we;
  logic [3:0]  vram_be;
  logic [31:0] vram_wdata, vram_rdata;
  logic        pf_overrun;

  int checks = 0;
  int failures = 0;

  always #5 pixel_clk = ~pixel_clk;

  text_vram_arbiter dut (
    .pixel_clk       (pixel_clk),
    .Reset           (Reset),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .disp_data       (disp_data),
    .avl_addr        (avl_addr),
    .avl_read        (avl_read),
    .avl_write       (avl_write),
    .avl_byteenable  (avl_byteenable),
    .avl_writedata   (avl_writedata),
    .avl_readdata    (avl_readdata),
    .avl_waitrequest (avl_waitrequest),
    .vram_addr       (vram_addr),
    .vram_we         (vram_we),
    .vram_be         (vram_be),
    .vram_wdata      (vram_wdata),
    .vram_rdata      (vram_rdata),
    .pf_overrun      (pf_overrun)
  );

  // VRAM model: preset contents plus an overlay of words written through the port.
  logic [31:0] ovl_mem [0:2047];
  bit   [2047:0] ovl_vld;

  function automatic logic [31:0] init_val(input logic [10:0] a);
    return (a == 11'd40) ? 32'h4142_1F2E : {16'hC0DE, 5'd0, a};
  endfunction

  function automatic logic [31:0] cur(input logic [10:0] a);
    return ovl_vld[a] ? ovl_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  always @(posedge pixel_clk) begin
    if (vram_we) begin
      ovl_mem[vram_addr] <= merge(cur(vram_addr), vram_wdata, vram_be);
      ovl_vld[vram_addr] <= 1'b1;
    end
    vram_rdata <= cur(vram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge pixel_clk);
  endtask

  task automatic cpu_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
    cyc(); avl_read = 1'b1; avl_addr = a; #1;
    chk({tag, "_wait"}, 32'(avl_waitrequest), 32'd1);
    cyc(); #1;
    chk({tag, "_ack"}, 32'(avl_waitrequest), 32'd0);
    chk({tag, "_data"}, avl_readdata, exp);
    cyc(); avl_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, hi, n;
    Reset = 1'b1; DrawX = '0; DrawY = '0;
    avl_addr = '0; avl_read = 1'b0; avl_write = 1'b0;
    avl_byteenable = '0; avl_writedata = '0;
    cyc(); cyc(); #1;
    chk("rst_vram_we", 32'(vram_we), 32'd0);
    cyc(); Reset = 1'b0; #1;
    chk("rst_disp", disp_data, 32'd0);
    chk("rst_overrun", 32'(pf_overrun), 32'd0);
    chk("rst_readdata", avl_readdata, 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_wait", 32'(avl_waitrequest), 32'd0);

    // single-cycle CPU write, partial byte lanes
    cyc(); DrawX = 10'd80; avl_write = 1'b1; avl_addr = 11'd5;
    avl_writedata = 32'hDEAD_BEEF; avl_byteenable = 4'b0011; #1;
    chk("wr_we", 32'(vram_we), 32'd1);
    chk("wr_be", 32'(vram_be), 32'd3);
    chk("wr_addr", 32'(vram_addr), 32'd5);
    chk("wr_wdata", vram_wdata, 32'hDEAD_BEEF);
    chk("wr_wait", 32'(avl_waitrequest), 32'd0);
    cyc(); avl_write = 1'b0; #1;
    chk("wr_no_snoop", disp_data, 32'd0);

    cpu_read("rd5", 11'd5, 32'hC0DE_BEEF);
    cpu_read("rd_oor", 11'd1300, 32'd0);

    cyc(); avl_write = 1'b1; avl_addr = 11'd1300;
    avl_writedata = 32'hFFFF_FFFF; avl_byteenable = 4'hF; #1;
    chk("wr_oor_we", 32'(vram_we), 32'd0);
    chk("wr_oor_wait", 32'(avl_waitrequest), 32'd0);
    cyc(); avl_write = 1'b0;

    // prefetch of row 1 on line 15
    cnt = 0;
    for (int x = 640; x <= 799; x++) begin
      cyc(); DrawY = 10'd15; DrawX = 10'(x); #1;
      if (x == 641) chk("pf1_addr_first", 32'(vram_addr), 32'd40);
      if (x == 680) chk("pf1_addr_last", 32'(vram_addr), 32'd79);
      if (x == 799) chk("pf1_pre_swap_disp", disp_data, 32'd0);
      if (vram_we) cnt++;
    end
    chk("pf1_no_vram_we", 32'(cnt), 32'd0);
    cyc(); DrawY = 10'd16; DrawX = 10'd0; #1;
    chk("row1_x0", disp_data, 32'h4142_1F2E);
    cyc(); DrawX = 10'd15; #1;
    chk("row1_x15", disp_data, 32'h4142_1F2E);
    cyc(); DrawX = 10'd16; #1;
    chk("row1_x16", disp_data, 32'hC0DE_0029);
    cyc(); DrawX = 10'd640; #1;
    chk("row1_idx40_clamp", disp_data, 32'h4142_1F2E);

    // CPU read colliding with a trigger: 42 prefetch stall cycles plus the
    // read's own address cycle before the acknowledge
    cyc(); DrawY = 10'd15; DrawX = 10'd640; avl_read = 1'b1; avl_addr = 11'd5; #1;
    hi = 0; n = 0;
    while (avl_waitrequest && n < 100) begin
      hi++; n++;
      cyc(); DrawX = DrawX + 10'd1; #1;
    end
    chk("pf_stall_cycles", 32'(hi), 32'd43);
    chk("pf_stall_rd_data", avl_readdata, 32'hC0DE_BEEF);
    cyc(); avl_read = 1'b0; DrawX = DrawX + 10'd1;
    while (DrawX < 10'd799) begin cyc(); DrawX = DrawX + 10'd1; end
    cyc(); DrawY = 10'd16; DrawX = 10'd0; #1;
    chk("pf2_no_overrun", 32'(pf_overrun), 32'd0);
    chk("row1_again_x0", disp_data, 32'h4142_1F2E);

    // line 524 preloads row 0, including the earlier CPU write
    for (int x = 640; x <= 799; x++) begin
      cyc(); DrawY = 10'd524; DrawX = 10'(x); #1;
      if (x == 641) chk("pf0_addr_first", 32'(vram_addr), 32'd0);
      if (x == 680) chk("pf0_addr_last", 32'(vram_addr), 32'd39);
    end
    cyc(); DrawY = 10'd0; DrawX = 10'd0; #1;
    chk("row0_x0", disp_data, 32'hC0DE_0000);
    cyc(); DrawX = 10'd80; #1;
    chk("row0_written_word", disp_data, 32'hC0DE_BEEF);
    cyc(); DrawX = 10'd624; #1;
    chk("row0_word39", disp_data, 32'hC0DE_0027);

    // line 479: no trigger and no swap
    cnt = 0;
    for (int x = 640; x <= 799; x++) begin
      cyc(); DrawY = 10'd479; DrawX = 10'(x); #1;
      if (vram_addr != 11'd0) cnt++;
    end
    chk("y479_no_prefetch", 32'(cnt), 32'd0);
    cyc(); DrawY = 10'd480; DrawX = 10'd0; #1;
    chk("y479_no_swap", disp_data, 32'hC0DE_0000);

    // reset in the middle of a prefetch
    for (int x = 640; x <= 661; x++) begin
      cyc(); DrawY = 10'd15; DrawX = 10'(x); #1;
    end
    chk("pf_word20_addr", 32'(vram_addr), 32'd60);
    cyc(); Reset = 1'b1; DrawX = 10'd662; #1;
    chk("rst_pf_we", 32'(vram_we), 32'd0);
    cyc(); Reset = 1'b0; DrawY = 10'd16; DrawX = 10'd0; #1;
    chk("rst_pf_bank_x0", disp_data, 32'd0);
    chk("rst_pf_overrun", 32'(pf_overrun), 32'd0);
    cyc(); DrawX = 10'd16; #1;
    chk("rst_pf_bank_x16", disp_data, 32'd0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(); DrawX = DrawX + 10'd1; #1;
      if (vram_we || vram_addr != 11'd0) cnt++;
    end
    chk("rst_pf_aborted", 32'(cnt), 32'd0);

    // forced swap right after the trigger -> overrun
    cyc(); DrawY = 10'd15; DrawX = 10'd640; #1;
    cyc(); DrawX = 10'd799; #1;
    chk("ovr_before_swap", 32'(pf_overrun), 32'd0);
    cyc(); DrawY = 10'd16; DrawX = 10'd0; #1;
    chk("ovr_set", 32'(pf_overrun), 32'd1);
    chk("ovr_bank1_zero", disp_data, 32'd0);
    for (int i = 0; i < 60; i++) begin cyc(); DrawX = DrawX + 10'd1; end
    #1;
    chk("ovr_sticky", 32'(pf_overrun), 32'd1);

    // reset with a read strobe held through it; serviced fresh afterwards
    cyc(); Reset = 1'b1; avl_read = 1'b1; avl_addr = 11'd5; #1;
    chk("rst_hold_wait", 32'(avl_waitrequest), 32'd1);
    chk("rst_hold_readdata", avl_readdata, 32'd0);
    cyc(); Reset = 1'b0; #1;
    chk("ovr_cleared", 32'(pf_overrun), 32'd0);
    chk("fresh_rd_wait", 32'(avl_waitrequest), 32'd1);
    chk("fresh_rd_addr", 32'(vram_addr), 32'd5);
    cyc(); #1;
    chk("fresh_rd_ack", 32'(avl_waitrequest), 32'd0);
    chk("fresh_rd_data", avl_readdata, 32'hC0DE_BEEF);
    cyc(); avl_read = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
